pu_riscv_muldiv_sequencer: RTL and testbench

PU_RISCV_MULDIV_SEQUENCER -- requirements
Module: pu_riscv_muldiv_sequencer

---
 rtl/pu_riscv_muldiv_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pu_riscv_muldiv_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_riscv_muldiv_sequencer.sv
// Sequencer for the RISC-V M extension: accepts one op, starts the multiplier or divider, returns the result.
// Optional define PU_RISCV_DIV_ZERO_BYPASS_EN resolves divide-by-zero in the sequencer and does not start the divider.
module pu_riscv_muldiv_sequencer #(
    parameter int XLEN        = 64,
    parameter int MUL_LATENCY = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_func3,
    input  logic            req_word,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            mul_start,
    output logic            div_start,
    output logic [XLEN-1:0] unit_opA,
    output logic [XLEN-1:0] unit_opB,
    output logic [2:0]      unit_func3,
    output logic            unit_word,
    input  logic [XLEN-1:0] mul_r,
    input  logic [XLEN-1:0] div_r,
    input  logic            div_done,
    output logic            muldiv_stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_result
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_stateNxt;
    logic [3:0]        r_mulCnt;
    logic [3:0]        w_mulCntNxt;
    logic              r_mulStart;
    logic              r_divStart;
    logic [XLEN-1:0]   r_unitOpA;
    logic [XLEN-1:0]   r_unitOpB;
    logic [2:0]        r_unitFunc3;
    logic              r_unitWord;
    logic [XLEN-1:0]   r_rspResult;

    logic              w_accept;
    logic              w_isDiv;
    logic              w_mulLast;
    logic              w_divByZero;
    logic [XLEN-1:0]   w_bypassResult;
    logic              w_capture;
    logic [XLEN-1:0]   w_captureVal;

    assign w_accept  = (r_state == IDLE) && req_valid && !flush;
    assign w_isDiv   = req_func3[2];
    assign w_mulLast = (r_mulCnt == 4'(MUL_LATENCY - 1));

`ifdef PU_RISCV_DIV_ZERO_BYPASS_EN
    // Quotient by zero is all-ones; remainder by zero is the dividend (sign-extended for *W ops).
    always_comb begin
        w_divByZero    = 1'b0;
        w_bypassResult = '0;
        if (w_isDiv) begin
            w_divByZero = req_word ? (opB[31:0] == 32'd0) : (opB == '0);
        end
        if (!req_func3[1]) begin
            w_bypassResult = '1;
        end else if (req_word) begin
            w_bypassResult        = {XLEN{opA[31]}};
            w_bypassResult[31:0]  = opA[31:0];
        end else begin
            w_bypassResult = opA;
        end
    end
`else
    assign w_divByZero    = 1'b0;
    assign w_bypassResult = '0;
`endif

    always_comb begin
        w_stateNxt   = r_state;
        w_mulCntNxt  = r_mulCnt;
        w_capture    = 1'b0;
        w_captureVal = '0;
        if (flush) begin
            w_stateNxt  = IDLE;
            w_mulCntNxt = 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_mulCntNxt = 4'd0;
                    if (req_valid) begin
                        if (!w_isDiv) begin
                            w_stateNxt = MUL;
                        end else if (w_divByZero) begin
                            w_stateNxt   = DONE;
                            w_capture    = 1'b1;
                            w_captureVal = w_bypassResult;
                        end else begin
                            w_stateNxt = DIV;
                        end
                    end
                end
                MUL: begin
                    if (w_mulLast) begin
                        w_stateNxt   = DONE;
                        w_mulCntNxt  = 4'd0;
                        w_capture    = 1'b1;
                        w_captureVal = mul_r;
                    end else begin
                        w_mulCntNxt = r_mulCnt + 4'd1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        w_stateNxt   = DONE;
                        w_capture    = 1'b1;
                        w_captureVal = div_r;
                    end
                end
                DONE: begin
                    if (!ex_stall) begin
                        w_stateNxt = IDLE;
                    end
                end
                default: begin
                    w_stateNxt  = IDLE;
                    w_mulCntNxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_mulCnt <= 4'd0;
        end else begin
            r_state  <= w_stateNxt;
            r_mulCnt <= w_mulCntNxt;
        end
    end

    // Start pulses are registered so they land in the first MUL/DIV cycle only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mulStart <= 1'b0;
            r_divStart <= 1'b0;
        end else begin
            r_mulStart <= w_accept && !w_isDiv;
            r_divStart <= w_accept && w_isDiv && !w_divByZero;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_unitOpA   <= '0;
            r_unitOpB   <= '0;
            r_unitFunc3 <= 3'd0;
            r_unitWord  <= 1'b0;
        end else if (w_accept) begin
            r_unitOpA   <= opA;
            r_unitOpB   <= opB;
            r_unitFunc3 <= req_func3;
            r_unitWord  <= req_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rspResult <= '0;
        end else if (w_capture) begin
            r_rspResult <= w_captureVal;
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign rsp_valid    = (r_state == DONE);
    assign rsp_result   = r_rspResult;
    assign mul_start    = r_mulStart;
    assign div_start    = r_divStart;
    assign unit_opA     = r_unitOpA;
    assign unit_opB     = r_unitOpB;
    assign unit_func3   = r_unitFunc3;
    assign unit_word    = r_unitWord;
    // Stall is gated by reset so it reads 0 while rstn is held low even if a request is offered.
    assign muldiv_stall = rstn && ((r_state == MUL) || (r_state == DIV) ||
                                   ((r_state == IDLE) && req_valid && !flush));

endmodule

// File: tb/tb_pu_riscv_muldiv_sequencer.sv
// Self-checking bench for pu_riscv_muldiv_sequencer: vector table, directed corner sequences, random ops.
// Honours PU_RISCV_DIV_ZERO_BYPASS_EN to pick the expected divide-by-zero timing.
module tb_pu_riscv_muldiv_sequencer;

    localparam int MUL_LAT = 3;
    localparam logic [63:0] ALL1 = {64{1'b1}};

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_func3;
    logic        req_word;
    logic [63:0] opA;
    logic [63:0] opB;
    logic        ex_stall;
    logic        flush;
    logic        mul_start;
    logic        div_start;
    logic [63:0] unit_opA;
    logic [63:0] unit_opB;
    logic [2:0]  unit_func3;
    logic        unit_word;
    logic [63:0] mul_r;
    logic [63:0] div_r;
    logic        div_done;
    logic        muldiv_stall;
    logic        rsp_valid;
    logic [63:0] rsp_result;

    int nVec = 0;
    int nErr = 0;
    int divDelay = 0;

    always #5 clk = ~clk;

    pu_riscv_muldiv_sequencer #(.XLEN(64), .MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_func3(req_func3), .req_word(req_word), .opA(opA), .opB(opB),
        .ex_stall(ex_stall), .flush(flush), .mul_start(mul_start), .div_start(div_start),
        .unit_opA(unit_opA), .unit_opB(unit_opB), .unit_func3(unit_func3), .unit_word(unit_word),
        .mul_r(mul_r), .div_r(div_r), .div_done(div_done), .muldiv_stall(muldiv_stall),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result)
    );

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Architectural result of an M-extension op, straight from the ISA definition.
    function automatic logic [63:0] refCalc(input logic [2:0] f, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] pa;
        logic signed [129:0] pb;
        logic [129:0]        p;
        logic signed [63:0]  sa;
        logic signed [63:0]  sb;
        logic signed [31:0]  sa32;
        logic signed [31:0]  sb32;
        logic [31:0]         a32;
        logic [31:0]         b32;
        logic [31:0]         lo32;
        a32  = a[31:0];
        b32  = b[31:0];
        sa   = a;
        sb   = b;
        sa32 = a32;
        sb32 = b32;
        pa   = (f == 3'd3) ? $signed({66'd0, a}) : $signed({{66{a[63]}}, a});
        pb   = (f == 3'd1) ? $signed({{66{b[63]}}, b}) : $signed({66'd0, b});
        p    = pa * pb;
        case (f)
            3'd0: begin
                lo32 = a32 * b32;
                return w ? sext32(lo32) : a * b;
            end
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: begin
                if (w) begin
                    if (b32 == 32'd0) return ALL1;
                    if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sext32(a32);
                    return sext32(sa32 / sb32);
                end
                if (b == 64'd0) return ALL1;
                if (a == 64'h8000_0000_0000_0000 && b == ALL1) return a;
                return sa / sb;
            end
            3'd5: begin
                if (w) return (b32 == 32'd0) ? ALL1 : sext32(a32 / b32);
                return (b == 64'd0) ? ALL1 : a / b;
            end
            3'd6: begin
                if (w) begin
                    if (b32 == 32'd0) return sext32(a32);
                    if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
                    return sext32(sa32 % sb32);
                end
                if (b == 64'd0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == ALL1) return 64'd0;
                return sa % sb;
            end
            default: begin
                if (w) return (b32 == 32'd0) ? sext32(a32) : sext32(a32 % b32);
                return (b == 64'd0) ? a : a % b;
            end
        endcase
    endfunction

    assign mul_r = refCalc(unit_func3, unit_word, unit_opA, unit_opB);

    // Divider model: keeps running regardless of flush; div_r holds junk outside the done cycle.
    logic        divPending;
    int          divCnt;
    logic [63:0] divRes;
    always @(negedge clk) begin
        div_done <= 1'b0;
        div_r    <= 64'hBADD_BADD_BADD_BADD;
        if (div_start) begin
            if (divDelay == 0) begin
                div_done   <= 1'b1;
                div_r      <= refCalc(unit_func3, unit_word, unit_opA, unit_opB);
                divPending <= 1'b0;
            end else begin
                divPending <= 1'b1;
                divCnt     <= divDelay - 1;
                divRes     <= refCalc(unit_func3, unit_word, unit_opA, unit_opB);
            end
        end else if (divPending) begin
            if (divCnt == 0) begin
                div_done   <= 1'b1;
                div_r      <= divRes;
                divPending <= 1'b0;
            end else begin
                divCnt <= divCnt - 1;
            end
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        int          dly;
        int          stallCyc;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
        req_valid = v;
        req_func3 = f3;
        req_word  = w;
        opA       = a;
        opB       = b;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE back to IDLE with cycle-exact checks.
    task automatic doTxn(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input int dly, input int stallCyc,
                         input logic [63:0] exp);
        bit isDiv;
        bit byp;
        int lat;
        isDiv = f3[2];
        byp   = 1'b0;
`ifdef PU_RISCV_DIV_ZERO_BYPASS_EN
        byp = isDiv && (w ? (b[31:0] == 32'd0) : (b == 64'd0));
`endif
        lat      = !isDiv ? MUL_LAT + 1 : (byp ? 1 : dly + 2);
        divDelay = dly;
        checkOutput("ready_idle", {63'd0, req_ready}, 64'd1);
        applyStimulus(1'b1, f3, w, a, b);
        #1;
        checkOutput("stall_on_offer", {63'd0, muldiv_stall}, 64'd1);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) nextCycle();
            checkOutput("mul_start", {63'd0, mul_start}, {63'd0, (k == 1) && !isDiv});
            checkOutput("div_start", {63'd0, div_start}, {63'd0, (k == 1) && isDiv && !byp});
            checkOutput("req_ready_busy", {63'd0, req_ready}, 64'd0);
            if (k == 1) checkOutput("unit_opA", unit_opA, a);
            if (k < lat) begin
                checkOutput("rsp_valid_early", {63'd0, rsp_valid}, 64'd0);
                checkOutput("stall_busy", {63'd0, muldiv_stall}, 64'd1);
            end else begin
                checkOutput("rsp_valid", {63'd0, rsp_valid}, 64'd1);
                checkOutput("rsp_result", rsp_result, exp);
                checkOutput("stall_done", {63'd0, muldiv_stall}, 64'd0);
            end
        end
        for (int j = 0; j < stallCyc; j++) begin
            ex_stall = 1'b1;
            nextCycle();
            checkOutput("rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
            checkOutput("rsp_result_held", rsp_result, exp);
            checkOutput("ready_held_low", {63'd0, req_ready}, 64'd0);
        end
        ex_stall = 1'b0;
        nextCycle();
        checkOutput("ready_after", {63'd0, req_ready}, 64'd1);
        checkOutput("rsp_valid_after", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 64'd7, 64'd6, 0, 0, 64'd42};
        tbl[1]  = '{3'd5, 1'b0, 64'd100, 64'd7, 10, 0, 64'd14};
        tbl[2]  = '{3'd7, 1'b0, 64'd100, 64'd7, 3, 0, 64'd2};
        tbl[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 2, 3, 64'hFFFF_FFFF_FFFF_FFFA};
        tbl[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[5]  = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 0, 0, 64'd2};
        tbl[6]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0, 1, ALL1};
        tbl[7]  = '{3'd2, 1'b0, 64'd2, ALL1, 0, 0, 64'd1};
        tbl[8]  = '{3'd0, 1'b1, 64'h4000_0000, 64'd2, 0, 0, 64'hFFFF_FFFF_8000_0000};
        tbl[9]  = '{3'd5, 1'b0, 64'h1234, 64'd0, 4, 0, ALL1};
        tbl[10] = '{3'd7, 1'b0, 64'h55, 64'd0, 4, 0, 64'h55};
        tbl[11] = '{3'd4, 1'b0, 64'd5, 64'd0, 2, 0, ALL1};
        tbl[12] = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFF_8000_0000};
        tbl[13] = '{3'd7, 1'b1, 64'h1_8000_0005, 64'h5_0000_0000, 3, 2, 64'hFFFF_FFFF_8000_0005};
        tbl[14] = '{3'd1, 1'b0, ALL1, ALL1, 0, 0, 64'd0};
        tbl[15] = '{3'd5, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'h1_0000_0007, 0, 0, 64'd14};

        rstn     = 1'b0;
        ex_stall = 1'b0;
        flush    = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
        #1;
        checkOutput("reset_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset_stall", {63'd0, muldiv_stall}, 64'd0);
        checkOutput("reset_starts", {62'd0, mul_start, div_start}, 64'd0);
        checkOutput("reset_result", rsp_result, 64'd0);
        nextCycle();
        nextCycle();
        rstn = 1'b1;
        nextCycle();

        for (int i = 0; i < 16; i++) begin
            doTxn(tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].stallCyc, tbl[i].exp);
        end

        // Flush offered together with a request in IDLE: nothing accepted.
        applyStimulus(1'b1, 3'd0, 1'b0, 64'd3, 64'd3);
        flush = 1'b1;
        #1;
        checkOutput("flush_idle_stall", {63'd0, muldiv_stall}, 64'd0);
        nextCycle();
        flush = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
        checkOutput("flush_idle_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("flush_idle_nostart", {62'd0, mul_start, div_start}, 64'd0);
        nextCycle();

        // Flush two cycles into DIV; the late div_done must be ignored.
        divDelay = 6;
        applyStimulus(1'b1, 3'd5, 1'b0, 64'd100, 64'd7);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
        checkOutput("flushdiv_start", {63'd0, div_start}, 64'd1);
        nextCycle();
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        checkOutput("flushdiv_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("flushdiv_stall", {63'd0, muldiv_stall}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            checkOutput("flushdiv_no_rsp", {63'd0, rsp_valid}, 64'd0);
            checkOutput("flushdiv_idle", {63'd0, req_ready}, 64'd1);
        end
        doTxn(3'd0, 1'b0, 64'd7, 64'd6, 0, 0, 64'd42);

        // Flush while stalled in DONE drops the response.
        applyStimulus(1'b1, 3'd0, 1'b0, 64'd3, 64'd5);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
        for (int k = 0; k < MUL_LAT; k++) nextCycle();
        checkOutput("flushdone_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("flushdone_result", rsp_result, 64'd15);
        ex_stall = 1'b1;
        flush    = 1'b1;
        nextCycle();
        ex_stall = 1'b0;
        flush    = 1'b0;
        checkOutput("flushdone_dropped", {63'd0, rsp_valid}, 64'd0);
        checkOutput("flushdone_ready", {63'd0, req_ready}, 64'd1);

        // Reset asserted in the second MUL cycle.
        applyStimulus(1'b1, 3'd0, 1'b0, 64'd9, 64'd9);
        nextCycle();
        nextCycle();
        rstn = 1'b0;
        applyStimulus(1'b1, 3'd0, 1'b0, 64'd9, 64'd9);
        #1;
        checkOutput("rst_mul_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("rst_mul_stall", {63'd0, muldiv_stall}, 64'd0);
        checkOutput("rst_mul_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_mul_starts", {62'd0, mul_start, div_start}, 64'd0);
        checkOutput("rst_mul_unitA", unit_opA, 64'd0);
        checkOutput("rst_mul_result", rsp_result, 64'd0);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 1'b0, 64'd0, 64'd0);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            checkOutput("rst_after_valid", {63'd0, rsp_valid}, 64'd0);
            checkOutput("rst_after_ready", {63'd0, req_ready}, 64'd1);
        end

        // Random ops against the ISA-level model.
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  f3;
            logic        w;
            logic [63:0] a;
            logic [63:0] b;
            f3 = 3'($urandom_range(0, 7));
            w  = ((f3 == 3'd0) || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) b = 64'd0;
            doTxn(f3, w, a, b, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                  refCalc(f3, w, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
